// File: rtl/swap_pkg.sv
// Shared encodings for the swap controller and its register-file stage.
package swap_pkg;
   localparam logic [1:0] SEL_IDLE    = 2'd0;
   localparam logic [1:0] SEL_SAVE    = 2'd1;
   localparam logic [1:0] SEL_MOVE    = 2'd2;
   localparam logic [1:0] SEL_RESTORE = 2'd3;

   typedef enum logic [1:0] {
      EXP1 = 2'd0,
      EXP2 = 2'd1,
      EXP3 = 2'd2
   } trk_e;
endpackage

// File: rtl/swap_seq_checker.sv
// Tracks the save/move/restore step order and flags protocol errors.
module swap_seq_checker
   import swap_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       w,
   input  logic [1:0] sel,
   input  logic       err_clr,
   output logic       seq_err,
   output logic       step_ok_done
);

   trk_e r_state;
   trk_e w_nxt;
   logic w_err;
   logic w_done;
   logic r_err;

   always_comb begin
      w_nxt  = r_state;
      w_err  = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         EXP1: begin
            if (w) begin
               if (sel == SEL_SAVE) w_nxt = EXP2;
               else                 w_err = 1'b1;
            end
         end
         EXP2: begin
            if (w && sel == SEL_MOVE) begin
               w_nxt = EXP3;
            end else if (w && sel == SEL_SAVE) begin
               w_err = 1'b1;
               w_nxt = EXP2;
            end else begin
               w_err = 1'b1;
               w_nxt = EXP1;
            end
         end
         EXP3: begin
            if (w && sel == SEL_RESTORE) begin
               w_nxt  = EXP1;
               w_done = 1'b1;
            end else if (w && sel == SEL_SAVE) begin
               w_err = 1'b1;
               w_nxt = EXP2;
            end else begin
               w_err = 1'b1;
               w_nxt = EXP1;
            end
         end
         default: w_nxt = EXP1;
      endcase
   end

   // A new error takes precedence over a simultaneous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= EXP1;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_err)        r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
      end
   end

   assign seq_err      = r_err;
   assign step_ok_done = w_done;

endmodule

// File: rtl/swap_regfile.sv
// A/B/T register file driven by the swap controller's write steps.
module swap_regfile
   import swap_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w,
   input  logic [1:0]        sel,
   input  logic              load_en,
   input  logic              load_sel,
   input  logic [DATA_W-1:0] load_data,
   input  logic              err_clr,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              swap_done,
   output logic [CNT_W-1:0]  swap_cnt,
   output logic              seq_err
);

   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_t;
   logic              r_done;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_ok;

   swap_seq_checker u_chk (
      .clk          (clk),
      .reset        (reset),
      .w            (w),
      .sel          (sel),
      .err_clr      (err_clr),
      .seq_err      (seq_err),
      .step_ok_done (w_ok)
   );

   // Controller steps win over loads; out-of-order steps still write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a <= '0;
         r_b <= '0;
         r_t <= '0;
      end else if (w) begin
         unique case (sel)
            SEL_SAVE:    r_t <= r_a;
            SEL_MOVE:    r_a <= r_b;
            SEL_RESTORE: r_b <= r_t;
            default:     ;
         endcase
      end else if (load_en) begin
         if (load_sel) r_b <= load_data;
         else          r_a <= load_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_done <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_done <= w_ok;
         if (w_ok) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign a_out     = r_a;
   assign b_out     = r_b;
   assign swap_done = r_done;
   assign swap_cnt  = r_cnt;

endmodule

// File: tb/tb_swap_regfile.sv
// Table-driven and scoreboard checks for swap_regfile.
module tb_swap_regfile;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       w = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       load_en = 1'b0;
   logic       load_sel = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       err_clr = 1'b0;
   logic [7:0] a_out;
   logic [7:0] b_out;
   logic       swap_done;
   logic [3:0] swap_cnt;
   logic       seq_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   swap_regfile #(.DATA_W(8), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .w         (w),
      .sel       (sel),
      .load_en   (load_en),
      .load_sel  (load_sel),
      .load_data (load_data),
      .err_clr   (err_clr),
      .a_out     (a_out),
      .b_out     (b_out),
      .swap_done (swap_done),
      .swap_cnt  (swap_cnt),
      .seq_err   (seq_err)
   );

   typedef struct {
      logic       w;
      logic [1:0] sel;
      logic       le;
      logic       ls;
      logic [7:0] ld;
      logic       ec;
      logic [7:0] ea;
      logic [7:0] eb;
      logic       edone;
      logic [3:0] ecnt;
      logic       eerr;
      string      name;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[19];

   function automatic vec_t mk(logic iw, logic [1:0] isel, logic le,
                               logic ls, logic [7:0] ld, logic ec,
                               logic [7:0] ea, logic [7:0] eb,
                               logic ed, logic [3:0] ecnt, logic ee,
                               string nm);
      vec_t v;
      v.w = iw; v.sel = isel; v.le = le; v.ls = ls; v.ld = ld;
      v.ec = ec; v.ea = ea; v.eb = eb; v.edone = ed;
      v.ecnt = ecnt; v.eerr = ee; v.name = nm;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(vec_t v);
      vec_t e;
      w = v.w; sel = v.sel; load_en = v.le; load_sel = v.ls;
      load_data = v.ld; err_clr = v.ec;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.name, ".a"}, 32'(a_out), 32'(e.ea));
      chk({e.name, ".b"}, 32'(b_out), 32'(e.eb));
      chk({e.name, ".done"}, 32'(swap_done), 32'(e.edone));
      chk({e.name, ".cnt"}, 32'(swap_cnt), 32'(e.ecnt));
      chk({e.name, ".err"}, 32'(seq_err), 32'(e.eerr));
   endtask

   initial begin
      logic [7:0] ma, mb, mt;
      logic [3:0] mcnt;
      int pulses;

      tbl[0]  = mk(0,0,1,0,8'h3C,0, 8'h3C,8'h00,0,0,0, "loadA");
      tbl[1]  = mk(0,0,1,1,8'hA5,0, 8'h3C,8'hA5,0,0,0, "loadB");
      tbl[2]  = mk(1,1,0,0,8'h00,0, 8'h3C,8'hA5,0,0,0, "s1");
      tbl[3]  = mk(1,2,0,0,8'h00,0, 8'hA5,8'hA5,0,0,0, "s2");
      tbl[4]  = mk(1,3,0,0,8'h00,0, 8'hA5,8'h3C,1,1,0, "s3");
      tbl[5]  = mk(0,0,0,0,8'h00,0, 8'hA5,8'h3C,0,1,0, "idle");
      tbl[6]  = mk(1,1,0,0,8'h00,0, 8'hA5,8'h3C,0,1,0, "g1");
      tbl[7]  = mk(0,0,0,0,8'h00,0, 8'hA5,8'h3C,0,1,1, "gap");
      tbl[8]  = mk(1,2,0,0,8'h00,0, 8'h3C,8'h3C,0,1,1, "g2");
      tbl[9]  = mk(1,3,0,0,8'h00,0, 8'h3C,8'hA5,0,1,1, "g3");
      tbl[10] = mk(0,0,0,0,8'h00,1, 8'h3C,8'hA5,0,1,0, "clr");
      tbl[11] = mk(1,0,0,0,8'h00,0, 8'h3C,8'hA5,0,1,1, "sel0");
      tbl[12] = mk(1,0,0,0,8'h00,1, 8'h3C,8'hA5,0,1,1, "clrset");
      tbl[13] = mk(0,0,0,0,8'h00,1, 8'h3C,8'hA5,0,1,0, "clr2");
      tbl[14] = mk(1,1,1,0,8'hFF,0, 8'h3C,8'hA5,0,1,0, "ldrop");
      tbl[15] = mk(0,0,1,0,8'hFF,0, 8'hFF,8'hA5,0,1,1, "ldok");
      tbl[16] = mk(0,0,0,0,8'h00,1, 8'hFF,8'hA5,0,1,0, "clr3");
      tbl[17] = mk(1,3,0,0,8'h00,0, 8'hFF,8'h3C,0,1,1, "tval");
      tbl[18] = mk(0,0,0,0,8'h00,1, 8'hFF,8'h3C,0,1,0, "clr4");

      #3;
      chk("rst.a", 32'(a_out), 0);
      chk("rst.b", 32'(b_out), 0);
      chk("rst.done", 32'(swap_done), 0);
      chk("rst.cnt", 32'(swap_cnt), 0);
      chk("rst.err", 32'(seq_err), 0);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i]);

      ma = 8'hFF; mb = 8'h3C; mt = 8'h3C; mcnt = 4'd1; pulses = 0;
      for (int n = 0; n < 16; n++) begin
         mt = ma;
         run_vec(mk(1,1,0,0,0,0, ma,mb,0,mcnt,0, "w1"));
         ma = mb;
         run_vec(mk(1,2,0,0,0,0, ma,mb,0,mcnt,0, "w2"));
         mb = mt;
         mcnt = mcnt + 4'd1;
         run_vec(mk(1,3,0,0,0,0, ma,mb,1,mcnt,0, "w3"));
         if (swap_done === 1'b1) pulses++;
      end
      chk("wrap.pulses", 32'(pulses), 16);
      chk("wrap.cnt", 32'(swap_cnt), 1);
      chk("wrap.a", 32'(a_out), 32'h FF);
      chk("wrap.b", 32'(b_out), 32'h3C);
      run_vec(mk(0,0,0,0,0,0, 8'hFF,8'h3C,0,4'd1,0, "wrap.idle"));

      run_vec(mk(1,1,0,0,0,0, 8'hFF,8'h3C,0,1,0, "r1"));
      run_vec(mk(1,2,0,0,0,0, 8'h3C,8'h3C,0,1,0, "r2"));
      w = 1'b0; sel = 2'd0;
      #2 reset = 1'b0;
      #1;
      chk("arst.a", 32'(a_out), 0);
      chk("arst.b", 32'(b_out), 0);
      chk("arst.done", 32'(swap_done), 0);
      chk("arst.cnt", 32'(swap_cnt), 0);
      chk("arst.err", 32'(seq_err), 0);
      #1 reset = 1'b1;
      run_vec(mk(0,0,1,0,8'h11,0, 8'h11,8'h00,0,0,0, "p.ldA"));
      run_vec(mk(0,0,1,1,8'h22,0, 8'h11,8'h22,0,0,0, "p.ldB"));
      run_vec(mk(1,1,0,0,0,0, 8'h11,8'h22,0,0,0, "p1"));
      run_vec(mk(1,2,0,0,0,0, 8'h22,8'h22,0,0,0, "p2"));
      run_vec(mk(1,3,0,0,0,0, 8'h22,8'h11,1,1,0, "p3"));
      run_vec(mk(0,0,0,0,0,0, 8'h22,8'h11,0,1,0, "p.idle"));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
